lvt_2w4r_select: RTL and testbench
==================================

Name: lvt_2w4r_select

Overview:
- Live Value Table (LVT) plus read-select stage for a 2-write/4-read register file.
- The file is built from two 1-write/4-read memory banks. Write port 0 feeds bank 0; write port 1 feeds bank 1.
- Tracks which write port last wrote each address and steers each of the 4 read ports to the bank holding the live value.
- Consumes the 4 read outputs of each bank; its outputs are the register file's read ports.

Parameters:
- DATA_WIDTH, 32, register word width.
- ADDR_WIDTH, 4, register address width; the LVT has 2**ADDR_WIDTH entries.
- BYPASS, 1: 1 = same-cycle write-to-read forwarding; 0 = reads return the pre-write value.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- we_0  in  1  write enable, port 0 (bank 0).
- write_addr_0  in  ADDR_WIDTH  write address, port 0.
- write_data_0  in  DATA_WIDTH  write data, port 0 (used only for bypass).
- we_1  in  1  write enable, port 1 (bank 1).
- write_addr_1  in  ADDR_WIDTH  write address, port 1.
- write_data_1  in  DATA_WIDTH  write data, port 1 (used only for bypass).
- read_addr_k  in  ADDR_WIDTH  read address, k = 0..3; the same value drives both banks' read_addr_k.
- bank0_data_k  in  DATA_WIDTH  bank 0 read_data_k (combinational read).
- bank1_data_k  in  DATA_WIDTH  bank 1 read_data_k.
- read_data_k  out  DATA_WIDTH  selected live value, k = 0..3.
- collision  out  1  registered one-cycle pulse: both ports wrote the same address in the previous cycle.
- collision_count  out  16  saturating count of collisions.

Behaviour:
- State:
  - lvt[2**ADDR_WIDTH] holds 1 bit per entry (the bank holding the live value).
  - written[2**ADDR_WIDTH] holds 1 bit per entry (address has been written since reset).
- Reset (reset_n low, asynchronous):
  - All lvt and written bits cleared to 0.
  - collision = 0, collision_count = 0.
  - read_data_k is combinational and is not reset-gated; during reset it equals bank0_data_k, because lvt reads 0.
  - Reset asserted mid-operation discards any in-progress write to the LVT; the bank contents are unaffected.
- LVT update, at each rising edge with reset_n high:
  - we_0 only: lvt[write_addr_0] <= 0, written <= 1.
  - we_1 only: lvt[write_addr_1] <= 1, written <= 1.
  - Both enabled, different addresses: both entries updated.
  - Both enabled, same address: port 1 wins, lvt <= 1. collision <= 1 for exactly the next cycle; otherwise collision <= 0.
- collision_count increments on each collision and saturates at 16'hFFFF (no wrap).
- Read path is combinational with zero added latency:
  - sel_k = lvt[read_addr_k].
  - read_data_k = sel_k ? bank1_data_k : bank0_data_k.
  - An unwritten address returns bank0_data_k, which the banks define as their init content.
- Bypass (BYPASS = 1), priority order:
  - If we_1 and write_addr_1 == read_addr_k: read_data_k = write_data_1.
  - Else if we_0 and write_addr_0 == read_addr_k: read_data_k = write_data_0.
  - Else the LVT-selected bank data.
  - The priority mirrors the collision rule, so the forwarded value always equals the value visible next cycle.
- BYPASS = 0: the same-cycle read returns the old live value; the new value is visible from the next cycle.
- All four read ports are independent. Any number may hit the same address; each sees identical data.
- Address compare uses the full ADDR_WIDTH; there is no aliasing or wrap-around.
- X on we_* is not permitted after reset release. Assertion: we_0/we_1 are never X while reset_n is high.

Test Plan:
- Reset then read: assert reset_n=0, release. All read_addr_k = 3, bank0_data=32'hA, bank1_data=32'hB -> read_data_k = 32'hA, collision=0, collision_count=0.
- Port-1 ownership: we_1=1, write_addr_1=5, one cycle; then read_addr_0=5 with bank1_data_0=32'h1234 -> read_data_0=32'h1234. A subsequent we_0 to address 5 -> read_data_0 follows bank0_data_0.
- Collision: we_0=we_1=1, both addresses 7 -> next cycle collision=1 for exactly one cycle, collision_count=1, lvt[7] selects bank 1. Repeat 65536 times -> count stays at 16'hFFFF.
- Bypass (BYPASS=1): we_0=1, addr 2, data 32'hDEAD; read_addr_1=2 same cycle -> read_data_1=32'hDEAD. With both ports writing addr 2 (port 1 data 32'hBEEF) -> 32'hBEEF. BYPASS=0 -> old bank value same cycle, new value next cycle.
- Four-port independence: read addresses 0, 5, 5, 15 with mixed LVT owners -> each output matches its own bank select; duplicated address 5 gives equal outputs.
- Reset mid-write: drop reset_n asynchronously between edges after writes to addresses 1 and 9 via port 1 -> all LVT entries read bank 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/lvt_2w4r_select.sv
// Live Value Table and read-select stage for a 2-write/4-read register file
// built from two 1-write/4-read banks (write port 0 -> bank 0, port 1 -> bank 1).
module lvt_2w4r_select #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  we_0,
    input  logic [ADDR_WIDTH-1:0] write_addr_0,
    input  logic [DATA_WIDTH-1:0] write_data_0,
    input  logic                  we_1,
    input  logic [ADDR_WIDTH-1:0] write_addr_1,
    input  logic [DATA_WIDTH-1:0] write_data_1,
    input  logic [ADDR_WIDTH-1:0] read_addr_0,
    input  logic [ADDR_WIDTH-1:0] read_addr_1,
    input  logic [ADDR_WIDTH-1:0] read_addr_2,
    input  logic [ADDR_WIDTH-1:0] read_addr_3,
    input  logic [DATA_WIDTH-1:0] bank0_data_0,
    input  logic [DATA_WIDTH-1:0] bank0_data_1,
    input  logic [DATA_WIDTH-1:0] bank0_data_2,
    input  logic [DATA_WIDTH-1:0] bank0_data_3,
    input  logic [DATA_WIDTH-1:0] bank1_data_0,
    input  logic [DATA_WIDTH-1:0] bank1_data_1,
    input  logic [DATA_WIDTH-1:0] bank1_data_2,
    input  logic [DATA_WIDTH-1:0] bank1_data_3,
    output logic [DATA_WIDTH-1:0] read_data_0,
    output logic [DATA_WIDTH-1:0] read_data_1,
    output logic [DATA_WIDTH-1:0] read_data_2,
    output logic [DATA_WIDTH-1:0] read_data_3,
    output logic                  collision,
    output logic [15:0]           collision_count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DEPTH-1:0]      lvt_q, lvt_d;
    logic [DEPTH-1:0]      written_q, written_d;
    logic                  collision_q, collision_d;
    logic [15:0]           count_q, count_d;

    logic [ADDR_WIDTH-1:0] raddr [4];
    logic [DATA_WIDTH-1:0] bank0 [4];
    logic [DATA_WIDTH-1:0] bank1 [4];
    logic [DATA_WIDTH-1:0] rdata [4];

    // Port 1 is applied last so it owns the entry when both ports hit one address.
    always_comb begin
        lvt_d     = lvt_q;
        written_d = written_q;
        if (we_0) begin
            lvt_d[write_addr_0]     = 1'b0;
            written_d[write_addr_0] = 1'b1;
        end
        if (we_1) begin
            lvt_d[write_addr_1]     = 1'b1;
            written_d[write_addr_1] = 1'b1;
        end
        collision_d = we_0 & we_1 & (write_addr_0 == write_addr_1);
        count_d     = count_q;
        if (collision_d && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lvt_q       <= '0;
            written_q   <= '0;
            collision_q <= 1'b0;
            count_q     <= '0;
        end else begin
            lvt_q       <= lvt_d;
            written_q   <= written_d;
            collision_q <= collision_d;
            count_q     <= count_d;
        end
    end

    assign raddr[0] = read_addr_0;
    assign raddr[1] = read_addr_1;
    assign raddr[2] = read_addr_2;
    assign raddr[3] = read_addr_3;
    assign bank0[0] = bank0_data_0;
    assign bank0[1] = bank0_data_1;
    assign bank0[2] = bank0_data_2;
    assign bank0[3] = bank0_data_3;
    assign bank1[0] = bank1_data_0;
    assign bank1[1] = bank1_data_1;
    assign bank1[2] = bank1_data_2;
    assign bank1[3] = bank1_data_3;

    // Forwarding priority matches the write-collision rule, so the bypassed
    // value is exactly what the LVT will select on the following cycle.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            rdata[k] = lvt_q[raddr[k]] ? bank1[k] : bank0[k];
            if (BYPASS) begin
                if (we_1 && (write_addr_1 == raddr[k])) begin
                    rdata[k] = write_data_1;
                end else if (we_0 && (write_addr_0 == raddr[k])) begin
                    rdata[k] = write_data_0;
                end
            end
        end
    end

    assign read_data_0     = rdata[0];
    assign read_data_1     = rdata[1];
    assign read_data_2     = rdata[2];
    assign read_data_3     = rdata[3];
    assign collision       = collision_q;
    assign collision_count = count_q;

    we_known_a: assert property (@(posedge clock) disable iff (!reset_n)
        !$isunknown({we_0, we_1}));

endmodule

// File: tb/tb_lvt_2w4r_select.sv
// Randomized and directed bench for lvt_2w4r_select; a BYPASS=1 and a BYPASS=0
// instance share every input and are checked against an address-ownership model.
module tb_lvt_2w4r_select;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int N  = 1 << AW;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          we_0, we_1;
    logic [AW-1:0] wa0, wa1;
    logic [DW-1:0] wd0, wd1;
    logic [AW-1:0] ra [4];
    logic [DW-1:0] b0 [4];
    logic [DW-1:0] b1 [4];
    logic [DW-1:0] rd [4];
    logic [DW-1:0] rdn [4];
    logic          coll, colln;
    logic [15:0]   cnt, cntn;

    bit owner [N];
    bit exp_coll;
    int exp_cnt;
    int cmp_n = 0;
    int err_n = 0;

    always #5 clock = ~clock;

    lvt_2w4r_select #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(1'b1)) dut (
        .clock(clock), .reset_n(reset_n),
        .we_0(we_0), .write_addr_0(wa0), .write_data_0(wd0),
        .we_1(we_1), .write_addr_1(wa1), .write_data_1(wd1),
        .read_addr_0(ra[0]), .read_addr_1(ra[1]), .read_addr_2(ra[2]), .read_addr_3(ra[3]),
        .bank0_data_0(b0[0]), .bank0_data_1(b0[1]), .bank0_data_2(b0[2]), .bank0_data_3(b0[3]),
        .bank1_data_0(b1[0]), .bank1_data_1(b1[1]), .bank1_data_2(b1[2]), .bank1_data_3(b1[3]),
        .read_data_0(rd[0]), .read_data_1(rd[1]), .read_data_2(rd[2]), .read_data_3(rd[3]),
        .collision(coll), .collision_count(cnt)
    );

    lvt_2w4r_select #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(1'b0)) dut_nb (
        .clock(clock), .reset_n(reset_n),
        .we_0(we_0), .write_addr_0(wa0), .write_data_0(wd0),
        .we_1(we_1), .write_addr_1(wa1), .write_data_1(wd1),
        .read_addr_0(ra[0]), .read_addr_1(ra[1]), .read_addr_2(ra[2]), .read_addr_3(ra[3]),
        .bank0_data_0(b0[0]), .bank0_data_1(b0[1]), .bank0_data_2(b0[2]), .bank0_data_3(b0[3]),
        .bank1_data_0(b1[0]), .bank1_data_1(b1[1]), .bank1_data_2(b1[2]), .bank1_data_3(b1[3]),
        .read_data_0(rdn[0]), .read_data_1(rdn[1]), .read_data_2(rdn[2]), .read_data_3(rdn[3]),
        .collision(colln), .collision_count(cntn)
    );

    // Expected read value: most recent writer owns the address, port 1 wins ties.
    function automatic logic [DW-1:0] exp_rd(int k, bit byp);
        if (byp && we_1 && wa1 == ra[k]) return wd1;
        if (byp && we_0 && wa0 == ra[k]) return wd0;
        return owner[ra[k]] ? b1[k] : b0[k];
    endfunction

    task automatic model_reset();
        for (int a = 0; a < N; a++) owner[a] = 1'b0;
        exp_coll = 1'b0;
        exp_cnt  = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        if (reset_n) begin
            if (we_0) owner[wa0] = 1'b0;
            if (we_1) owner[wa1] = 1'b1;
            exp_coll = we_0 && we_1 && (wa0 == wa1);
            if (exp_coll && exp_cnt < 65535) exp_cnt++;
        end
        #1;
    endtask

    task automatic idle();
        we_0 = 1'b0;
        we_1 = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
        reset_n = 1'b0;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            ra[k] = 4'd3; b0[k] = 32'hA; b1[k] = 32'hB;
        end
        #2;
        for (int k = 0; k < 4; k++) begin
            cmp_n++;
            if (rd[k] !== 32'hA) begin
                err_n++; $display("FAIL reset_hold_rd%0d got %h want %h", k, rd[k], 32'hA);
            end
        end
        cmp_n++;
        if (coll !== 1'b0 || cnt !== 16'd0) begin
            err_n++; $display("FAIL reset_hold_coll got %b/%h want 0/0", coll, cnt);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            cmp_n++;
            if (rd[k] !== 32'hA || rdn[k] !== 32'hA) begin
                err_n++; $display("FAIL reset_rel_rd%0d got %h/%h want %h", k, rd[k], rdn[k], 32'hA);
            end
        end
        cmp_n++;
        if (coll !== 1'b0 || cnt !== 16'd0 || colln !== 1'b0 || cntn !== 16'd0) begin
            err_n++; $display("FAIL reset_rel_coll got %b/%h want 0/0", coll, cnt);
        end
    endtask

    task automatic test_port1_ownership();
        we_1 = 1'b1; wa1 = 4'd5; wd1 = $urandom;
        tick();
        idle();
        ra[0] = 4'd5; b1[0] = 32'h1234; b0[0] = 32'h5678;
        #1;
        cmp_n++;
        if (rd[0] !== 32'h1234 || rdn[0] !== 32'h1234) begin
            err_n++; $display("FAIL own_p1 got %h/%h want %h", rd[0], rdn[0], 32'h1234);
        end
        we_0 = 1'b1; wa0 = 4'd5; wd0 = $urandom;
        tick();
        idle();
        b0[0] = 32'h9ABC;
        #1;
        cmp_n++;
        if (rd[0] !== 32'h9ABC || rdn[0] !== 32'h9ABC) begin
            err_n++; $display("FAIL own_p0 got %h/%h want %h", rd[0], rdn[0], 32'h9ABC);
        end
    endtask

    task automatic test_four_port();
        we_0 = 1'b1; wa0 = 4'd0; we_1 = 1'b1; wa1 = 4'd5;
        tick();
        we_0 = 1'b0; wa1 = 4'd15;
        tick();
        idle();
        ra[0] = 4'd0; ra[1] = 4'd5; ra[2] = 4'd5; ra[3] = 4'd15;
        for (int k = 0; k < 4; k++) begin
            b0[k] = $urandom; b1[k] = $urandom;
        end
        b0[2] = b0[1]; b1[2] = b1[1];
        #1;
        cmp_n++;
        if (rd[0] !== b0[0] || rd[1] !== b1[1] || rd[3] !== b1[3]) begin
            err_n++; $display("FAIL four_port_sel got %h %h %h want %h %h %h",
                              rd[0], rd[1], rd[3], b0[0], b1[1], b1[3]);
        end
        cmp_n++;
        if (rd[2] !== rd[1] || rd[2] !== b1[1]) begin
            err_n++; $display("FAIL four_port_dup got %h/%h want %h", rd[1], rd[2], b1[1]);
        end
        for (int k = 0; k < 4; k++) begin
            cmp_n++;
            if (rd[k] !== exp_rd(k, 1'b1)) begin
                err_n++; $display("FAIL four_port_rd%0d got %h want %h", k, rd[k], exp_rd(k, 1'b1));
            end
        end
    endtask

    task automatic test_bypass();
        idle();
        ra[1] = 4'd2; b0[1] = 32'h0000_0B00; b1[1] = 32'h0000_1111;
        we_0 = 1'b1; wa0 = 4'd2; wd0 = 32'hDEAD;
        #1;
        cmp_n++;
        if (rd[1] !== 32'hDEAD || rdn[1] !== 32'h0000_0B00) begin
            err_n++; $display("FAIL bypass_p0 got %h/%h want %h/%h", rd[1], rdn[1], 32'hDEAD, 32'h0B00);
        end
        we_1 = 1'b1; wa1 = 4'd2; wd1 = 32'hBEEF;
        #1;
        cmp_n++;
        if (rd[1] !== 32'hBEEF || rdn[1] !== 32'h0000_0B00) begin
            err_n++; $display("FAIL bypass_both got %h/%h want %h/%h", rd[1], rdn[1], 32'hBEEF, 32'h0B00);
        end
        tick();
        idle();
        b1[1] = 32'hBEEF; b0[1] = 32'hDEAD;
        #1;
        cmp_n++;
        if (rd[1] !== 32'hBEEF || rdn[1] !== 32'hBEEF) begin
            err_n++; $display("FAIL bypass_next got %h/%h want %h", rd[1], rdn[1], 32'hBEEF);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            we_0 = 1'($urandom); we_1 = 1'($urandom);
            wa0 = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            wa1 = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            wd0 = $urandom; wd1 = $urandom;
            for (int k = 0; k < 4; k++) begin
                ra[k] = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
                b0[k] = $urandom; b1[k] = $urandom;
            end
            #1;
            for (int k = 0; k < 4; k++) begin
                cmp_n++;
                if (rd[k] !== exp_rd(k, 1'b1) || rdn[k] !== exp_rd(k, 1'b0)) begin
                    err_n++; $display("FAIL rand_rd%0d it%0d got %h/%h want %h/%h", k, i,
                                      rd[k], rdn[k], exp_rd(k, 1'b1), exp_rd(k, 1'b0));
                end
            end
            tick();
            cmp_n++;
            if (coll !== exp_coll || cnt !== exp_cnt[15:0] || colln !== exp_coll) begin
                err_n++; $display("FAIL rand_coll it%0d got %b/%h want %b/%h", i,
                                  coll, cnt, exp_coll, exp_cnt[15:0]);
            end
        end
        idle();
    endtask

    task automatic test_collision();
        logic [15:0] base;
        idle();
        tick();
        base = cnt;
        we_0 = 1'b1; we_1 = 1'b1; wa0 = 4'd7; wa1 = 4'd7; wd0 = $urandom; wd1 = $urandom;
        tick();
        idle();
        ra[0] = 4'd7; b0[0] = 32'h1111; b1[0] = 32'h2222;
        #1;
        cmp_n++;
        if (coll !== 1'b1 || cnt !== exp_cnt[15:0] || cnt !== base + 16'd1) begin
            err_n++; $display("FAIL coll_pulse got %b/%h want 1/%h", coll, cnt, base + 16'd1);
        end
        cmp_n++;
        if (rd[0] !== 32'h2222 || rdn[0] !== 32'h2222) begin
            err_n++; $display("FAIL coll_owner got %h/%h want %h", rd[0], rdn[0], 32'h2222);
        end
        tick();
        cmp_n++;
        if (coll !== 1'b0 || cnt !== base + 16'd1) begin
            err_n++; $display("FAIL coll_one_cycle got %b/%h want 0/%h", coll, cnt, base + 16'd1);
        end
        we_0 = 1'b1; we_1 = 1'b1;
        while (exp_cnt < 65535) tick();
        cmp_n++;
        if (cnt !== 16'hFFFF || coll !== 1'b1) begin
            err_n++; $display("FAIL coll_reach_max got %b/%h want 1/ffff", coll, cnt);
        end
        repeat (2) tick();
        idle();
        cmp_n++;
        if (cnt !== 16'hFFFF || cntn !== 16'hFFFF) begin
            err_n++; $display("FAIL coll_saturate got %h/%h want ffff", cnt, cntn);
        end
        tick();
        cmp_n++;
        if (coll !== 1'b0 || cnt !== 16'hFFFF) begin
            err_n++; $display("FAIL coll_sat_hold got %b/%h want 0/ffff", coll, cnt);
        end
    endtask

    task automatic test_reset_mid_write();
        idle();
        we_1 = 1'b1; wa1 = 4'd1;
        tick();
        wa1 = 4'd9;
        tick();
        idle();
        ra[0] = 4'd1; ra[1] = 4'd9; ra[2] = 4'd0; ra[3] = 4'd2;
        for (int k = 0; k < 4; k++) begin
            b0[k] = 32'h0B0B_0000 + k; b1[k] = 32'h1B1B_0000 + k;
        end
        #1;
        cmp_n++;
        if (rd[0] !== b1[0] || rd[1] !== b1[1]) begin
            err_n++; $display("FAIL midrst_pre got %h %h want %h %h", rd[0], rd[1], b1[0], b1[1]);
        end
        we_1 = 1'b1; wa1 = 4'd3; wd1 = $urandom;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 4; k++) begin
            cmp_n++;
            if (rd[k] !== b0[k] || rd[k] !== exp_rd(k, 1'b1)) begin
                err_n++; $display("FAIL midrst_rd%0d got %h want %h", k, rd[k], b0[k]);
            end
        end
        cmp_n++;
        if (coll !== 1'b0 || cnt !== 16'd0) begin
            err_n++; $display("FAIL midrst_coll got %b/%h want 0/0", coll, cnt);
        end
        @(posedge clock);
        @(negedge clock);
        idle();
        reset_n = 1'b1;
        ra[0] = 4'd3;
        #1;
        cmp_n++;
        if (rd[0] !== b0[0] || rdn[0] !== b0[0]) begin
            err_n++; $display("FAIL midrst_discard got %h/%h want %h", rd[0], rdn[0], b0[0]);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_port1_ownership();
        test_four_port();
        test_bypass();
        test_random();
        test_collision();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end
endmodule
